bcd_sum_display: RTL and testbench
==================================

# bcd_sum_display

Downstream consumer of the registered 9-bit two-digit BCD sum (`{carry, tens, ones}`). It captures each new sum and drives a 3-digit time-multiplexed common-anode-style 7-segment display with leading-zero blanking. A blank guard cycle separates digit switches to prevent ghosting, and non-BCD digits are flagged. The display shows the hundreds digit (0/1), the tens digit and the ones digit.

## Interface
- `REFRESH_DIV`, 1000: clock cycles per digit slot; legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset.
  - One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  one-cycle-or-longer strobe; `sum` is captured on every edge where it is high.
- `sum`  in  9  `{carry, tens[3:0], ones[3:0]}` from the adder's output register.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-high, registered.
- `an`  out  3  digit enables, active-high one-hot: ones=001, tens=010, hundreds=100; 000 = all off. Registered.
- `err`  out  1  high while the displayed snapshot holds a tens or ones digit > 9. Registered.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the hundreds slot. Registered.

## Operation
- **Hold register (9 bits).** Loads `sum` on any edge with `in_valid`=1. Holds otherwise.
- **Snapshot register (9 bits).** Copied from the hold register at the start of each frame (first cycle of the ones slot). A mid-frame capture is never displayed until the next frame.
  - If `in_valid` is high on the same edge as the snapshot copy, the snapshot takes the old hold value. The new value appears one frame later.
- **Slot counter.** Runs 0..REFRESH_DIV-1 and wraps.
- **Digit-state FSM.** States ONES → TENS → HUNDS → ONES. It advances when the counter wraps.
- **Frame.** One frame is 3·REFRESH_DIV cycles.
- **Within each slot:**
  - Counter value 0 is the guard cycle: `an`=000, `seg`=0x00.
  - Counter values 1..REFRESH_DIV-1: `an` = the one-hot code for the current state, and `seg` = that digit's encoding.
- **Encoding (seg hex).**
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Digit > 9: 40 (dash).
  - Blank: 00.
- **Blanking rules.**
  - Hundreds digit: shows 06 when carry=1, otherwise blank.
  - Tens digit: blank when carry=0 and tens=0. Otherwise shown, including 0 when carry=1.
  - Ones digit: always shown.
  - A blanked digit still gets its slot; `an` is asserted with `seg`=00, so frame timing stays fixed.
- **err.** Updated at each snapshot copy: 1 if snapshot tens>9 or ones>9, else 0. Constant for the whole frame.
- **frame_done.** Asserted exactly on the cycle where state=HUNDS and counter=REFRESH_DIV-1. Never asserted otherwise.

## Timing
- **Reset values.** While `rst_n`=0: `seg`=00, `an`=000, `err`=0, `frame_done`=0, hold=0, snapshot=0, counter=0, state=ONES. Takes effect immediately, without waiting for a clock edge.
- **After reset release.**
  - The first rising edge with `rst_n`=1 performs a snapshot copy and starts the ones slot.
  - Outputs show the guard cycle for that edge's cycle, then ones-slot content from the next edge.
- **Output registration.** All outputs are registered and reflect the state and counter of the same cycle; there is no combinational path from inputs.
- **Capture-to-display latency.** Data captured at edge t is visible at the first frame start after t, at most 3·REFRESH_DIV cycles later, plus 1 guard cycle.
- **REFRESH_DIV=2.** Each slot is 1 guard cycle followed by 1 lit cycle; the pattern is 000, 001, 000, 010, 000, 100, repeating.
- **Reset mid-frame.** Aborts immediately. The display restarts from the ones slot of a fresh frame showing 0, because the hold register was cleared.

## Test plan
- **Reset.** Reset, release, idle with `in_valid`=0 and REFRESH_DIV=4 → `an` sequence 000, 001×3, 000, 010×3, 000, 100×3, repeating.
  - `seg`=3F in the ones slot, 00 in the tens and hundreds slots.
  - `err`=0.
  - `frame_done` high on every 12th cycle only.
- **Full value.** Load `sum`=1_0100_0111 (147) → from the next frame: ones slot `seg`=07, tens slot 66, hundreds slot 06. `err`=0.
- **Leading-zero cases.**
  - Load 0_0000_0101 (5) → tens and hundreds slots `seg`=00, ones 6D.
  - Load 1_0000_0000 (100) → tens 3F, hundreds 06.
- **Invalid digit.** Load 0_1100_0011 → tens `seg`=40, ones 4F, `err`=1 for the whole frame. A following load of 0_0010_0011 clears `err` at the next frame start.
- **Mid-frame and boundary captures.**
  - Pulse `in_valid` with 99 during the tens slot → the current frame is unchanged; 99 appears from the next frame.
  - Pulse `in_valid` exactly on the snapshot edge → the value is delayed one frame.
- **Reset mid-frame.** Assert `rst_n`=0 asynchronously mid-hundreds-slot → `an`, `seg`, `err` and `frame_done` go to 0 before the next clock edge. After release, the display restarts at the ones slot showing 3F.

Source files
------------

// File: rtl/bcd_sum_display.sv
// Time-multiplexed 3-digit 7-segment driver for a registered {carry, tens, ones} BCD sum.
// Each digit slot opens with one blank guard cycle; a frame snapshot keeps the digits consistent.
module bcd_sum_display #(
   parameter int REFRESH_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [8:0] sum,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       err,
   output logic       frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {ONES, TENS, HUNDS} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q;
   logic [8:0]       hold_q, hold_d;
   logic [8:0]       snap_q, snap_d;
   logic             snap_load;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic             err_q, err_d;
   logic             fd_q, fd_d;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = in_valid ? sum : hold_q;

      // The first edge out of reset opens the ones slot with its guard cycle.
      if (start_q) begin
         state_d = ONES;
         cnt_d   = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
         case (state_q)
            ONES:    state_d = TENS;
            TENS:    state_d = HUNDS;
            default: state_d = ONES;
         endcase
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      snap_load = (cnt_d == '0) && (state_d == ONES);
      snap_d    = snap_load ? hold_q : snap_q;
      err_d     = snap_load ? ((hold_q[7:4] > 4'd9) || (hold_q[3:0] > 4'd9)) : err_q;

      // Outputs are computed from next state so they line up with the counter of their cycle.
      seg_d = 7'h00;
      an_d  = 3'b000;
      if (cnt_d != '0) begin
         case (state_d)
            ONES: begin
               an_d  = 3'b001;
               seg_d = seg7(snap_d[3:0]);
            end
            TENS: begin
               an_d  = 3'b010;
               seg_d = (snap_d[8] || (snap_d[7:4] != 4'd0)) ? seg7(snap_d[7:4]) : 7'h00;
            end
            default: begin
               an_d  = 3'b100;
               seg_d = snap_d[8] ? 7'h06 : 7'h00;
            end
         endcase
      end
      fd_d = (state_d == HUNDS) && (cnt_d == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ONES;
         cnt_q   <= '0;
         start_q <= 1'b1;
         hold_q  <= '0;
         snap_q  <= '0;
         seg_q   <= '0;
         an_q    <= '0;
         err_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= 1'b0;
         hold_q  <= hold_d;
         snap_q  <= snap_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
         fd_q    <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign err        = err_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Directed bench for bcd_sum_display at REFRESH_DIV=4: a frame-position model predicts
// {an, seg, err, frame_done} for every cycle through an expectation queue.
module tb_bcd_sum_display;

   localparam int DIV   = 4;
   localparam int FRAME = 3 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [8:0] sum = '0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       err;
   logic       frame_done;

   int compared = 0;
   int mismatched = 0;

   logic [11:0] exp_q[$];

   // Reference model state
   bit         m_first;
   int         m_p;
   logic [8:0] m_hold, m_snap;
   logic       m_err;
   logic [6:0] enc_tbl[16];

   bcd_sum_display #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sum(sum),
      .seg(seg), .an(an), .err(err), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   function automatic logic [6:0] enc(input logic [3:0] d);
      return enc_tbl[d];
   endfunction

   task automatic model_reset();
      m_first = 1'b1;
      m_p     = 0;
      m_hold  = '0;
      m_snap  = '0;
      m_err   = 1'b0;
   endtask

   function automatic logic [11:0] model_out();
      int         c, slot;
      logic [2:0] a;
      logic [6:0] s;
      c    = m_p % DIV;
      slot = m_p / DIV;
      a    = 3'b000;
      s    = 7'h00;
      if (c != 0) begin
         a = 3'(1 << slot);
         if (slot == 0) s = enc(m_snap[3:0]);
         else if (slot == 1) s = (m_snap[8] || m_snap[7:4] != 0) ? enc(m_snap[7:4]) : 7'h00;
         else s = m_snap[8] ? 7'h06 : 7'h00;
      end
      return {a, s, m_err, (m_p == FRAME - 1)};
   endfunction

   task automatic model_edge(input logic v, input logic [8:0] s);
      if (m_first) begin
         m_first = 1'b0;
         m_p     = 0;
      end else begin
         m_p = (m_p + 1) % FRAME;
      end
      if (m_p == 0) begin
         m_snap = m_hold;
         m_err  = (m_hold[7:4] > 9) || (m_hold[3:0] > 9);
      end
      if (v) m_hold = s;
   endtask

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed an/seg/err/fd=%h expected %h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
   task automatic cycle(input string tag, input logic v, input logic [8:0] s);
      in_valid = v;
      sum      = s;
      model_edge(v, s);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      check(tag, {an, seg, err, frame_done}, exp_q.pop_front());
      in_valid = 1'b0;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, 9'h000);
   endtask

   // Advance until the model's next edge lands on frame position pt (bounded to one frame).
   task automatic run_until_next(input string tag, input int pt);
      for (int i = 0; i < FRAME; i++) begin
         if (((m_p + 1) % FRAME) == pt) return;
         cycle(tag, 1'b0, 9'h000);
      end
   endtask

   task automatic load(input string tag, input logic [8:0] s);
      cycle(tag, 1'b1, s);
   endtask

   initial begin
      enc_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      model_reset();

      // Reset state, including across clock edges
      #3;
      exp_q.push_back(12'h000);
      check("reset_state", {an, seg, err, frame_done}, exp_q.pop_front());
      @(posedge clk); #1;
      exp_q.push_back(12'h000);
      check("reset_hold", {an, seg, err, frame_done}, exp_q.pop_front());
      rst_n = 1'b1;

      idle("idle", 2 * FRAME);

      load("full147", 9'b1_0100_0111);
      idle("full147", 2 * FRAME);

      load("lz5", 9'b0_0000_0101);
      idle("lz5", 2 * FRAME);

      load("lz100", 9'b1_0000_0000);
      idle("lz100", 2 * FRAME);

      load("bad_digit", 9'b0_1100_0011);
      idle("bad_digit", 2 * FRAME);
      load("err_clear", 9'b0_0010_0011);
      idle("err_clear", 2 * FRAME);

      // Capture during the tens slot must not disturb the current frame
      run_until_next("mid", DIV + 2);
      load("mid99", 9'b0_1001_1001);
      idle("mid99", 2 * FRAME);

      // Capture on the snapshot edge itself is deferred one frame
      run_until_next("edge", 0);
      load("edge55", 9'b0_0101_0101);
      idle("edge55", 2 * FRAME + 2);

      // Asynchronous reset in the middle of the hundreds slot
      run_until_next("pre_rst", 2 * DIV + 2);
      idle("pre_rst", 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      exp_q.push_back(12'h000);
      check("async_rst", {an, seg, err, frame_done}, exp_q.pop_front());
      @(posedge clk); #1;
      exp_q.push_back(12'h000);
      check("rst_held", {an, seg, err, frame_done}, exp_q.pop_front());
      rst_n = 1'b1;
      idle("after_rst", FRAME + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
